// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and address-range helper for the register bank
package regfile_pkg;

    localparam int unsigned DEF_WIDTH    = 32;
    localparam int unsigned DEF_DEPTH    = 32;
    localparam bit          DEF_ZERO_REG = 1'b1;
    localparam bit          DEF_BYPASS   = 1'b1;

    // Widest address any legal DEPTH (<= 256) can need.
    localparam int unsigned MAX_AW = 8;

    // Unsigned compare, so the result does not depend on the caller's address width.
    function automatic logic addr_valid(input logic [MAX_AW-1:0] addr,
                                        input int unsigned       depth);
        return {{(32-MAX_AW){1'b0}}, addr} < depth;
    endfunction

endpackage

// File: rtl/regfile_word.sv
// rtl/regfile_word.sv - one storage word with async active-low clear and active-low load
module regfile_word
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             clrn_i,
    input  logic             wen_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge clrn_i) begin
        if (!clrn_i) begin
            q_o <= '0;
        end else if (!wen_i) begin
            q_o <= wdata_i;
        end
    end

endmodule

// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - DEPTH x WIDTH register bank, one write port, two registered read ports
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter bit          ZERO_REG = DEF_ZERO_REG,
    parameter bit          BYPASS   = DEF_BYPASS,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             clrn_i,
    input  logic             wen_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_a_i,
    input  logic [AW-1:0]    raddr_b_i,
    output logic [WIDTH-1:0] rdata_a_o,
    output logic [WIDTH-1:0] rdata_b_o,
    output logic             err_o
);

    logic [WIDTH-1:0] word_q [DEPTH];
    logic             w_valid;
    logic             ra_valid;
    logic             rb_valid;
    logic             wr_en;
    logic [WIDTH-1:0] rd_a_d;
    logic [WIDTH-1:0] rd_b_d;

    assign w_valid  = addr_valid(MAX_AW'(waddr_i), DEPTH);
    assign ra_valid = addr_valid(MAX_AW'(raddr_a_i), DEPTH);
    assign rb_valid = addr_valid(MAX_AW'(raddr_b_i), DEPTH);
    assign wr_en    = !wen_i && w_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        if (ZERO_REG && i == 0) begin : g_zero
            // No storage: writes to word 0 simply have nowhere to land.
            assign word_q[i] = '0;
        end else begin : g_reg
            logic load_n;
            assign load_n = !(wr_en && waddr_i == AW'(i));
            regfile_word #(
                .WIDTH (WIDTH)
            ) u_word (
                .clk_i   (clk_i),
                .clrn_i  (clrn_i),
                .wen_i   (load_n),
                .wdata_i (wdata_i),
                .q_o     (word_q[i])
            );
        end
    end

    // The zero-word check sits above the bypass so word 0 never forwards write data.
    always_comb begin
        rd_a_d = '0;
        if (ra_valid && !(ZERO_REG && raddr_a_i == '0)) begin
            if (BYPASS && wr_en && waddr_i == raddr_a_i) begin
                rd_a_d = wdata_i;
            end else begin
                rd_a_d = word_q[raddr_a_i];
            end
        end
    end

    always_comb begin
        rd_b_d = '0;
        if (rb_valid && !(ZERO_REG && raddr_b_i == '0)) begin
            if (BYPASS && wr_en && waddr_i == raddr_b_i) begin
                rd_b_d = wdata_i;
            end else begin
                rd_b_d = word_q[raddr_b_i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge clrn_i) begin
        if (!clrn_i) begin
            rdata_a_o <= '0;
            rdata_b_o <= '0;
            err_o     <= 1'b0;
        end else begin
            rdata_a_o <= rd_a_d;
            rdata_b_o <= rd_b_d;
            // Sticky: only reset clears it.
            err_o     <= err_o | (!wen_i && !w_valid) | !ra_valid | !rb_valid;
        end
    end

endmodule

// File: tb/tb_regfile_bank.sv
// tb/tb_regfile_bank.sv - directed vector bench for regfile_bank (default and small/no-bypass builds)
module tb_regfile_bank;

    logic        clk;
    logic        clrn;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra;
    logic [4:0]  rb;

    logic [31:0] f_a, f_b, s_a, s_b;
    logic        f_err, s_err;

    int total = 0;
    int bad   = 0;

    // Default build: DEPTH 32, word 0 hardwired, bypass on.
    regfile_bank u_full (
        .clk_i     (clk),
        .clrn_i    (clrn),
        .wen_i     (wen),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .raddr_a_i (ra),
        .raddr_b_i (rb),
        .rdata_a_o (f_a),
        .rdata_b_o (f_b),
        .err_o     (f_err)
    );

    // Small build: DEPTH 20 (same 5-bit address), word 0 ordinary, bypass off.
    regfile_bank #(
        .WIDTH    (32),
        .DEPTH    (20),
        .ZERO_REG (1'b0),
        .BYPASS   (1'b0)
    ) u_small (
        .clk_i     (clk),
        .clrn_i    (clrn),
        .wen_i     (wen),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .raddr_a_i (ra),
        .raddr_b_i (rb),
        .rdata_a_o (s_a),
        .rdata_b_o (s_b),
        .err_o     (s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] f_a;
        logic [31:0] f_b;
        logic [31:0] s_a;
        logic [31:0] s_b;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a, input logic [4:0] b);
        wen   = w;
        waddr = wa;
        wdata = wd;
        ra    = a;
        rb    = b;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 clrn = 1'b0;
        #1;
        chk("rst_f_err", {31'd0, f_err}, 32'd0);
        chk("rst_s_err", {31'd0, s_err}, 32'd0);
        chk("rst_f_a", f_a, 32'd0);
        chk("rst_s_b", s_b, 32'd0);
        @(posedge clk);
        #2 clrn = 1'b1;
    endtask

    initial begin
        clrn = 1'b1;
        drive(1'b1, 5'd0, 32'd0, 5'd0, 5'd0);
        #1 clrn = 1'b0;
        #2;
        chk("init_f_a", f_a, 32'd0);
        chk("init_f_b", f_b, 32'd0);
        chk("init_f_err", {31'd0, f_err}, 32'd0);
        chk("init_s_a", s_a, 32'd0);
        chk("init_s_b", s_b, 32'd0);
        chk("init_s_err", {31'd0, s_err}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 clrn = 1'b1;

        // Sweep every address after reset; the small build flags 20..31.
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'd0, 32'd0, 5'(i), 5'(i));
            tick();
            chk($sformatf("sweep_f_a[%0d]", i), f_a, 32'd0);
            chk($sformatf("sweep_f_b[%0d]", i), f_b, 32'd0);
            chk($sformatf("sweep_f_err[%0d]", i), {31'd0, f_err}, 32'd0);
            chk($sformatf("sweep_s_a[%0d]", i), s_a, 32'd0);
            chk($sformatf("sweep_s_err[%0d]", i), {31'd0, s_err}, (i >= 20) ? 32'd1 : 32'd0);
        end
        do_reset();

        // Fill words 1..31 with A5A5_0000 + index.
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'(i), 32'hA5A5_0000 + 32'(i), 5'd1, 5'd1);
            tick();
        end

        vecs[0] = '{1'b1, 5'd0,  32'h0000_0000, 5'd7,  5'd31, 32'hA5A5_0007, 32'hA5A5_001F, 32'hA5A5_0007, 32'h0000_0000};
        vecs[1] = '{1'b1, 5'd7,  32'hDEAD_BEEF, 5'd7,  5'd7,  32'hA5A5_0007, 32'hA5A5_0007, 32'hA5A5_0007, 32'hA5A5_0007};
        vecs[2] = '{1'b1, 5'd0,  32'h0000_0000, 5'd7,  5'd1,  32'hA5A5_0007, 32'hA5A5_0001, 32'hA5A5_0007, 32'hA5A5_0001};
        vecs[3] = '{1'b0, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{1'b1, 5'd0,  32'h0000_0000, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[5] = '{1'b0, 5'd5,  32'h1111_1111, 5'd5,  5'd6,  32'h1111_1111, 32'hA5A5_0006, 32'hA5A5_0005, 32'hA5A5_0006};
        vecs[6] = '{1'b0, 5'd5,  32'h2222_2222, 5'd5,  5'd5,  32'h2222_2222, 32'h2222_2222, 32'h1111_1111, 32'h1111_1111};
        vecs[7] = '{1'b1, 5'd0,  32'h0000_0000, 5'd5,  5'd5,  32'h2222_2222, 32'h2222_2222, 32'h2222_2222, 32'h2222_2222};
        vecs[8] = '{1'b0, 5'd19, 32'h0000_1234, 5'd19, 5'd18, 32'h0000_1234, 32'hA5A5_0012, 32'hA5A5_0013, 32'hA5A5_0012};
        vecs[9] = '{1'b1, 5'd0,  32'h0000_0000, 5'd19, 5'd20, 32'h0000_1234, 32'hA5A5_0014, 32'h0000_1234, 32'h0000_0000};

        for (int v = 0; v < 10; v++) begin
            drive(vecs[v].wen, vecs[v].waddr, vecs[v].wdata, vecs[v].ra, vecs[v].rb);
            tick();
            chk($sformatf("vec%0d_f_a", v), f_a, vecs[v].f_a);
            chk($sformatf("vec%0d_f_b", v), f_b, vecs[v].f_b);
            chk($sformatf("vec%0d_s_a", v), s_a, vecs[v].s_a);
            chk($sformatf("vec%0d_s_b", v), s_b, vecs[v].s_b);
            chk($sformatf("vec%0d_f_err", v), {31'd0, f_err}, 32'd0);
        end

        // Out-of-range handling on the DEPTH=20 build.
        do_reset();
        drive(1'b0, 5'd4, 32'h0000_0044, 5'd0, 5'd0);
        tick();
        chk("oor_pre_s_err", {31'd0, s_err}, 32'd0);
        drive(1'b0, 5'd25, 32'hBAD0_BAD0, 5'd4, 5'd4);
        tick();
        chk("oor_wr_s_err", {31'd0, s_err}, 32'd1);
        chk("oor_wr_s_a", s_a, 32'h0000_0044);
        chk("oor_wr_f_err", {31'd0, f_err}, 32'd0);
        drive(1'b1, 5'd0, 32'd0, 5'd31, 5'd5);
        tick();
        chk("oor_rd_s_a", s_a, 32'd0);
        chk("oor_rd_s_b", s_b, 32'd0);
        chk("oor_rd_f_a", f_a, 32'd0);
        drive(1'b1, 5'd0, 32'd0, 5'd25, 5'd4);
        tick();
        chk("oor_f_a25", f_a, 32'hBAD0_BAD0);
        chk("oor_s_b4", s_b, 32'h0000_0044);
        drive(1'b1, 5'd0, 32'd0, 5'd1, 5'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("oor_sticky%0d", k), {31'd0, s_err}, 32'd1);
        end

        // Async reset in the middle of a write burst.
        do_reset();
        drive(1'b0, 5'd1, 32'h0000_0011, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd2, 32'h0000_0022, 5'd1, 5'd1);
        tick();
        chk("burst_f_a", f_a, 32'h0000_0011);
        chk("burst_s_a", s_a, 32'h0000_0011);
        drive(1'b0, 5'd3, 32'h0000_0033, 5'd2, 5'd1);
        #2 clrn = 1'b0;
        #1;
        chk("async_f_a", f_a, 32'd0);
        chk("async_f_b", f_b, 32'd0);
        chk("async_s_a", s_a, 32'd0);
        chk("async_s_b", s_b, 32'd0);
        chk("async_f_err", {31'd0, f_err}, 32'd0);
        chk("async_s_err", {31'd0, s_err}, 32'd0);
        tick();
        chk("held_f_b", f_b, 32'd0);
        chk("held_s_b", s_b, 32'd0);
        #1 clrn = 1'b1;
        drive(1'b0, 5'd3, 32'h0000_0042, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd0, 32'd0, 5'd3, 5'd2);
        tick();
        chk("post_f_a", f_a, 32'h0000_0042);
        chk("post_s_a", s_a, 32'h0000_0042);
        chk("post_f_b", f_b, 32'd0);
        chk("post_s_b", s_b, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
